core_lsu: RTL

- Load/store unit placed directly downstream of the core's execute stage, between the core and data memory.
- Accepts one load or store per request: a one-hot op flag, the effective address and the store data.
- Runs a req/ack transaction with a variable-latency data memory using word-aligned address, byte enables and lane-replicated store data.
- Returns sign- or zero-extended load data with a one-cycle DONE pulse; flags misaligned, illegal and timed-out accesses without touching memory state.

---
 rtl/core_lsu.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/core_lsu.sv
// Load/store unit between the execute stage and a variable-latency req/ack data memory.
// Handles lane alignment, byte enables, load extension, misalign/illegal detection and timeout.
module core_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ,
    input  logic        I_LB,
    input  logic        I_LH,
    input  logic        I_LW,
    input  logic        I_LBU,
    input  logic        I_LHU,
    input  logic        I_SB,
    input  logic        I_SH,
    input  logic        I_SW,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RDATA,
    output logic        MISALIGN,
    output logic        ERR,
    output logic        D_REQ,
    input  logic        D_ACK,
    output logic [31:0] D_ADDR,
    output logic        D_WE,
    output logic [3:0]  D_BE,
    output logic [31:0] D_WDATA,
    input  logic [31:0] D_RDATA
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_t;

    state_t      state_q;
    logic        busy_q, done_q, misalign_q, err_q, d_req_q, d_we_q;
    logic [31:0] rdata_q, d_addr_q, d_wdata_q, cnt_q;
    logic [3:0]  d_be_q;
    logic        is_byte_q, is_half_q, sext_q;
    logic [1:0]  addr_lo_q;

    // Request decode, evaluated on the raw inputs while idle
    logic [7:0]  ops;
    logic        op_legal, is_byte, is_half, is_word, is_store, misalign;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;

    always_comb begin
        ops      = {I_SW, I_SH, I_SB, I_LHU, I_LBU, I_LW, I_LH, I_LB};
        op_legal = $onehot(ops);
        is_byte  = I_LB | I_LBU | I_SB;
        is_half  = I_LH | I_LHU | I_SH;
        is_word  = I_LW | I_SW;
        is_store = I_SB | I_SH | I_SW;
        misalign = (is_half & ADDR[0]) | (is_word & (ADDR[1:0] != 2'b00));
        req_be    = 4'b1111;
        req_wdata = WDATA;
        if (is_byte) begin
            req_be    = 4'b0001 << ADDR[1:0];
            req_wdata = {4{WDATA[7:0]}};
        end else if (is_half) begin
            req_be    = ADDR[1] ? 4'b1100 : 4'b0011;
            req_wdata = {2{WDATA[15:0]}};
        end
        if (!is_store) begin
            req_wdata = 32'h0;
        end
    end

    // Load extraction from the returned word using the latched lane
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        unique case (addr_lo_q)
            2'd0:    ld_byte = D_RDATA[7:0];
            2'd1:    ld_byte = D_RDATA[15:8];
            2'd2:    ld_byte = D_RDATA[23:16];
            default: ld_byte = D_RDATA[31:24];
        endcase
        ld_half = addr_lo_q[1] ? D_RDATA[31:16] : D_RDATA[15:0];
        if (is_byte_q) begin
            ld_data = {{24{sext_q & ld_byte[7]}}, ld_byte};
        end else if (is_half_q) begin
            ld_data = {{16{sext_q & ld_half[15]}}, ld_half};
        end else begin
            ld_data = D_RDATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
            d_req_q    <= 1'b0;
            d_addr_q   <= 32'h0;
            d_we_q     <= 1'b0;
            d_be_q     <= 4'h0;
            d_wdata_q  <= 32'h0;
            cnt_q      <= 32'h0;
            is_byte_q  <= 1'b0;
            is_half_q  <= 1'b0;
            sext_q     <= 1'b0;
            addr_lo_q  <= 2'b00;
        end else begin
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (REQ) begin
                        busy_q    <= 1'b1;
                        is_byte_q <= is_byte;
                        is_half_q <= is_half;
                        sext_q    <= I_LB | I_LH;
                        addr_lo_q <= ADDR[1:0];
                        if (!op_legal || misalign) begin
                            // Rejected before memory is touched
                            err_q      <= ~op_legal;
                            misalign_q <= op_legal & misalign;
                            done_q     <= 1'b1;
                            rdata_q    <= 32'h0;
                            state_q    <= StResp;
                        end else begin
                            d_req_q   <= 1'b1;
                            d_addr_q  <= {ADDR[31:2], 2'b00};
                            d_we_q    <= is_store;
                            d_be_q    <= req_be;
                            d_wdata_q <= req_wdata;
                            cnt_q     <= 32'h0;
                            state_q   <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (D_ACK) begin
                        if (!d_we_q) begin
                            rdata_q <= ld_data;
                        end
                        d_req_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                        if (TIMEOUT != 0 && cnt_q + 32'd1 == TIMEOUT) begin
                            d_req_q <= 1'b0;
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StResp;
                        end
                    end
                end
                StResp: begin
                    busy_q    <= 1'b0;
                    d_addr_q  <= 32'h0;
                    d_we_q    <= 1'b0;
                    d_be_q    <= 4'h0;
                    d_wdata_q <= 32'h0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign RDATA    = rdata_q;
    assign MISALIGN = misalign_q;
    assign ERR      = err_q;
    assign D_REQ    = d_req_q;
    assign D_ADDR   = d_addr_q;
    assign D_WE     = d_we_q;
    assign D_BE     = d_be_q;
    assign D_WDATA  = d_wdata_q;

endmodule
